// File: rtl/mem_requester_if.sv
// Request, response and memory-port bundle for mem_requester.
// master = request/consumer/memory side, slave = the requester itself.
interface mem_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_dout,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_en, mem_we, mem_addr, mem_din, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_dout,
        output req_ready, resp_valid, resp_rdata,
        output mem_en, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/mem_requester.sv
// Memory-port initiator: issues requests, tracks reads over the fixed
// read latency and returns data in order through a credit-protected FIFO.
module mem_requester #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                READ_LATENCY = 2,
    parameter int                RESP_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] MMIO_ADDR_1  = 'h0FFF,
    parameter logic [ADDR_W-1:0] MMIO_ADDR_2  = 'h1000
) (
    input logic            clock,
    input logic            rst,
    mem_requester_if.slave bus
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(READ_LATENCY + 1);

    logic [READ_LATENCY-1:0] infl_q, infl_d;
    logic [IW-1:0]           infl_cnt_q, infl_cnt_d;
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]       fifo_q [RESP_DEPTH];
    logic [DATA_W-1:0]       fifo_d [RESP_DEPTH];

    logic is_mmio;
    logic credit_ok;
    logic ready;
    logic accept;
    logic rd_issue;
    logic mmio_issue;
    logic ret;
    logic push;
    logic pop;

    always_comb begin
        is_mmio   = !bus.req_we &&
                    (bus.req_addr == MMIO_ADDR_1 || bus.req_addr == MMIO_ADDR_2);
        // Every accepted read owns a FIFO slot before it is issued.
        credit_ok = (int'(cnt_q) + int'(infl_cnt_q)) < RESP_DEPTH;
        ready     = !rst && (bus.req_we ||
                    (credit_ok && (!is_mmio || infl_cnt_q == '0)));
        accept     = bus.req_valid && ready;
        rd_issue   = accept && !bus.req_we && !is_mmio;
        mmio_issue = accept && is_mmio;
        ret        = infl_q[READ_LATENCY-1];
        // MMIO only issues with nothing in flight, so it never meets a return.
        push       = ret || mmio_issue;
        pop        = (cnt_q != '0) && bus.resp_ready;

        infl_d     = infl_q << 1;
        infl_d[0]  = rd_issue;
        infl_cnt_d = infl_cnt_q + IW'(rd_issue) - IW'(ret);
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(pop);

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wptr_q] = bus.mem_dout;
        end
    end

    always_comb begin
        bus.req_ready  = ready;
        bus.mem_en     = accept;
        bus.mem_we     = accept && bus.req_we;
        bus.mem_addr   = accept ? bus.req_addr : '0;
        bus.mem_din    = accept ? bus.req_wdata : '0;
        bus.resp_valid = cnt_q != '0;
        bus.resp_rdata = fifo_q[rptr_q];
        bus.busy       = (infl_cnt_q != '0) || (cnt_q != '0);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            infl_q     <= '0;
            infl_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            infl_q     <= infl_d;
            infl_cnt_q <= infl_cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a 2-cycle memory model
// that returns the two MMIO addresses combinationally.
module tb_mem_requester;
    logic clock = 1'b0;
    logic rst   = 1'b1;

    always #5 clock = ~clock;

    mem_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_requester dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [8192];
    logic        p1_v, p2_v;
    logic [12:0] p1_a, p2_a;
    logic        mmio_now;

    logic [31:0] got [$];
    int          next_addr;
    int          seen;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    assign mmio_now = bus.mem_en && !bus.mem_we &&
                      (bus.mem_addr == 32'h0FFF || bus.mem_addr == 32'h1000);
    assign bus.mem_dout = mmio_now ? mem[bus.mem_addr[12:0]] :
                          p2_v     ? mem[p2_a] : 32'h0;

    always @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1_a <= '0;
            p2_a <= '0;
        end else begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[12:0]] <= bus.mem_din;
            p1_v <= bus.mem_en && !bus.mem_we && !mmio_now;
            p1_a <= bus.mem_addr[12:0];
            p2_v <= p1_v;
            p2_a <= p1_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic rr);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.resp_ready = rr;
        #1;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 1'b0, 32'h0, 32'h0, rr);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        idle(1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        #1;
        chk("rst_rv", bus.resp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_en", bus.mem_en, 1'b0);

        // single read, 3-cycle turnaround
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        chk("wr_en", bus.mem_en, 1'b1);
        chk("wr_we", bus.mem_we, 1'b1);
        chk("wr_din", bus.mem_din, 32'hDEADBEEF);
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        chk("rd_ready", bus.req_ready, 1'b1);
        chk("rd_addr", bus.mem_addr, 32'h10);
        chk("rd_we", bus.mem_we, 1'b0);
        tick();
        idle(1'b1);
        chk("idle_addr", bus.mem_addr, 32'h0);
        chk("rd_rv_c1", bus.resp_valid, 1'b0);
        tick();
        chk("rd_rv_c2", bus.resp_valid, 1'b0);
        chk("rd_busy_c2", bus.busy, 1'b1);
        tick();
        chk("rd_rv_c3", bus.resp_valid, 1'b1);
        chk("rd_data_c3", bus.resp_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_rv_c4", bus.resp_valid, 1'b0);
        chk("rd_busy_c4", bus.busy, 1'b0);

        // credit limit with a stalled consumer
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, c, 32'h0, 1'b0);
            chk($sformatf("cr_ready%0d", c), bus.req_ready, 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        chk("cr_full4", bus.req_ready, 1'b0);
        tick();
        chk("cr_full5", bus.req_ready, 1'b0);
        tick();
        chk("cr_full6", bus.req_ready, 1'b0);
        chk("cr_busy", bus.busy, 1'b1);
        next_addr = 4;
        for (int k = 0; k < 40 && got.size() < 6; k++) begin
            drive(next_addr < 6, 1'b0, next_addr, 32'h0, 1'b1);
            if (bus.resp_valid) got.push_back(bus.resp_rdata);
            if (bus.req_valid && bus.req_ready) next_addr++;
            tick();
        end
        chk("ord_cnt", got.size(), 6);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("ord%0d", i), got[i], pat(i));
        idle(1'b1);
        tick();
        chk("ord_busy", bus.busy, 1'b0);

        // write then read-after-write
        drive(1'b1, 1'b1, 32'h20, 32'h1234, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        chk("raw_ready", bus.req_ready, 1'b1);
        tick();
        idle(1'b1);
        chk("raw_rv_c2", bus.resp_valid, 1'b0);
        tick();
        chk("raw_rv_c3", bus.resp_valid, 1'b0);
        tick();
        chk("raw_rv_c4", bus.resp_valid, 1'b1);
        chk("raw_data", bus.resp_rdata, 32'h1234);
        tick();

        // MMIO read held off behind a normal read
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        chk("mo_ready_c0", bus.req_ready, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0FFF, 32'h0, 1'b1);
        chk("mo_ready_c1", bus.req_ready, 1'b0);
        tick();
        chk("mo_ready_c2", bus.req_ready, 1'b0);
        tick();
        chk("mo_ready_c3", bus.req_ready, 1'b1);
        chk("mo_rv_c3", bus.resp_valid, 1'b1);
        chk("mo_data_c3", bus.resp_rdata, pat(32'h40));
        tick();
        idle(1'b1);
        chk("mo_rv_c4", bus.resp_valid, 1'b1);
        chk("mo_data_c4", bus.resp_rdata, pat(32'h0FFF));
        tick();
        chk("mo_rv_c5", bus.resp_valid, 1'b0);

        // MMIO zero-latency return of freshly written data
        drive(1'b1, 1'b1, 32'h0FFF, 32'hAB, 1'b1);
        tick();
        drive(1'b1, 1'b0, 32'h0FFF, 32'h0, 1'b1);
        chk("mw_ready", bus.req_ready, 1'b1);
        chk("mw_rv_issue", bus.resp_valid, 1'b0);
        tick();
        idle(1'b1);
        chk("mw_rv", bus.resp_valid, 1'b1);
        chk("mw_data", bus.resp_rdata, 32'hAB);
        tick();
        drive(1'b1, 1'b0, 32'h1000, 32'h0, 1'b1);
        chk("m2_ready", bus.req_ready, 1'b1);
        tick();
        idle(1'b1);
        chk("m2_rv", bus.resp_valid, 1'b1);
        chk("m2_data", bus.resp_rdata, pat(32'h1000));
        tick();

        // reset discards an in-flight read
        drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b1);
        chk("rs_ready", bus.req_ready, 1'b1);
        tick();
        idle(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_busy", bus.busy, 1'b0);
        chk("rs_ready_after", bus.req_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid) seen++;
            tick();
        end
        chk("rs_noresp", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
